// File: rtl/spidergon_pkg.sv
// Shared definitions for the Spidergon network-interface packetizer:
// flit type codes, flit field offsets and the packetizer state encoding.
package spidergon_pkg;

   localparam int TYPE_W = 2;

   localparam logic [1:0] FT_TAIL     = 2'b00;
   localparam logic [1:0] FT_HEAD     = 2'b01;
   localparam logic [1:0] FT_BODY     = 2'b10;
   localparam logic [1:0] FT_HDR_ONLY = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HEAD = 2'b01,
      ST_BODY = 2'b10,
      ST_DROP = 2'b11
   } state_e;

   function automatic int type_msb(input int flit_w);
      return flit_w - 1;
   endfunction

   function automatic int vc_msb(input int flit_w);
      return flit_w - 1 - TYPE_W;
   endfunction

   function automatic int dest_msb(input int flit_w, input int vc_w);
      return flit_w - 1 - TYPE_W - vc_w;
   endfunction

   function automatic int src_msb(input int flit_w, input int vc_w,
                                  input int dest_w);
      return flit_w - 1 - TYPE_W - vc_w - dest_w;
   endfunction

endpackage

// File: rtl/spidergon_sync_fifo.sv
// Synchronous show-ahead FIFO for payload words; power-of-two depth,
// extra pointer bit distinguishes full from empty.
module spidergon_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_push;
   logic             w_pop;

   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   assign empty    = (r_wptr == r_rptr);
   assign full     = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign pop_data = r_mem[r_rptr[AW-1:0]];

   // Storage write; contents need no reset since pointers gate reads.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr[AW-1:0]] <= push_data;
   end

   // Pointer update; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)
            r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/spidergon_ni_packetizer.sv
// Network-interface packetizer: turns a descriptor plus a payload word
// stream into head/body/tail flits, dropping packets addressed to self.
module spidergon_ni_packetizer
   import spidergon_pkg::*;
#(
   parameter int NUM_OF_NODES            = 8,
   parameter int FLIT_DATA_WIDTH         = 16,
   parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int NODE_IDENTIFIER         = 0,
   parameter int FIFO_DEPTH              = 4,
   localparam int DEST_W = $clog2(NUM_OF_NODES),
   localparam int VC_W   = $clog2(NUM_OF_VIRTUAL_CHANNELS),
   localparam int FLIT_W = FLIT_DATA_WIDTH + 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               desc_valid,
   output logic                               desc_ready,
   input  logic [DEST_W-1:0]                  desc_dest,
   input  logic [VC_W-1:0]                    desc_vc,
   input  logic [3:0]                         desc_len,
   input  logic                               word_valid,
   output logic                               word_ready,
   input  logic [FLIT_DATA_WIDTH-1:0]         word_data,
   output logic [FLIT_W-1:0]                  flit_out,
   output logic                               flit_out_valid,
   input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] flit_out_vc_full,
   output logic                               pkt_dropped,
   output logic [15:0]                        pkt_sent_count
);

   localparam int TYPE_MSB = type_msb(FLIT_W);
   localparam int VC_MSB   = vc_msb(FLIT_W);
   localparam int DEST_MSB = dest_msb(FLIT_W, VC_W);
   localparam int SRC_MSB  = src_msb(FLIT_W, VC_W, DEST_W);
   localparam logic [DEST_W-1:0] SRC_ID = DEST_W'(NODE_IDENTIFIER);

   state_e                     r_state;
   state_e                     w_state_nxt;
   logic [FLIT_W-1:0]          r_flit;
   logic                       r_valid;
   logic [VC_W-1:0]            r_vc;
   logic [3:0]                 r_left;
   logic [15:0]                r_count;

   logic                       w_full;
   logic                       w_empty;
   logic [FLIT_DATA_WIDTH-1:0] w_fifo_data;
   logic                       w_pop;
   logic                       w_xfer;
   logic                       w_can_load;
   logic                       w_desc_ready;
   logic                       w_accept;
   logic                       w_load_head;
   logic                       w_load_word;
   logic                       w_drop_pop;
   logic                       w_clear;
   logic                       w_sent;
   logic                       w_dropped;
   logic [FLIT_W-1:0]          w_head;
   logic [1:0]                 w_word_type;

   spidergon_sync_fifo #(
      .WIDTH (FLIT_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (word_valid && !w_full),
      .push_data (word_data),
      .pop       (w_pop),
      .pop_data  (w_fifo_data),
      .full      (w_full),
      .empty     (w_empty)
   );

   assign word_ready     = !w_full;
   assign desc_ready     = w_desc_ready;
   assign pkt_dropped    = w_dropped;
   assign flit_out       = r_flit;
   assign flit_out_valid = r_valid;
   assign pkt_sent_count = r_count;

   assign w_xfer      = r_valid && !flit_out_vc_full[r_vc];
   assign w_can_load  = !r_valid || w_xfer;
   assign w_pop       = w_load_word || w_drop_pop;
   assign w_word_type = (r_left == 4'd1) ? FT_TAIL : FT_BODY;

   // Head flit is built straight from the descriptor being accepted.
   always_comb begin
      w_head = '0;
      w_head[TYPE_MSB -: TYPE_W] =
         (desc_len == 4'd0) ? FT_HDR_ONLY : FT_HEAD;
      w_head[VC_MSB -: VC_W]     = desc_vc;
      w_head[DEST_MSB -: DEST_W] = desc_dest;
      w_head[SRC_MSB -: DEST_W]  = SRC_ID;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state and datapath controls.
   always_comb begin
      w_state_nxt  = r_state;
      w_desc_ready = 1'b0;
      w_accept     = 1'b0;
      w_load_head  = 1'b0;
      w_load_word  = 1'b0;
      w_drop_pop   = 1'b0;
      w_clear      = 1'b0;
      w_sent       = 1'b0;
      w_dropped    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_desc_ready = !reset;
            if (desc_valid && !reset) begin
               w_accept = 1'b1;
               if (desc_dest == SRC_ID) begin
                  w_state_nxt = ST_DROP;
               end else begin
                  w_state_nxt = ST_HEAD;
                  w_load_head = 1'b1;
               end
            end
         end
         ST_HEAD: begin
            if (w_xfer) begin
               if (r_left == 4'd0) begin
                  w_sent      = 1'b1;
                  w_clear     = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_BODY;
                  w_load_word = !w_empty;
                  w_clear     = w_empty;
               end
            end
         end
         ST_BODY: begin
            // r_left reaches zero only once the tail is loaded.
            if (w_xfer && r_left == 4'd0) begin
               w_sent      = 1'b1;
               w_clear     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_can_load && r_left != 4'd0) begin
               w_load_word = !w_empty;
               w_clear     = w_empty;
            end
         end
         ST_DROP: begin
            if (r_left == 4'd0) begin
               w_dropped   = !reset;
               w_state_nxt = ST_IDLE;
            end else begin
               w_drop_pop = !w_empty;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output flit register, descriptor capture and sent counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flit  <= '0;
         r_valid <= 1'b0;
         r_vc    <= '0;
         r_left  <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) begin
            r_vc   <= desc_vc;
            r_left <= desc_len;
         end
         if (w_load_head) begin
            r_flit  <= w_head;
            r_valid <= 1'b1;
         end else if (w_load_word) begin
            r_flit  <= {w_word_type, w_fifo_data};
            r_valid <= 1'b1;
            r_left  <= r_left - 4'd1;
         end else if (w_clear) begin
            r_valid <= 1'b0;
         end
         if (w_drop_pop)
            r_left <= r_left - 4'd1;
         if (w_sent)
            r_count <= r_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_spidergon_ni_packetizer.sv
// Self-checking bench for spidergon_ni_packetizer: packet-level model
// with a per-cycle flit compare plus directed literal checks.
module tb_spidergon_ni_packetizer;

   localparam int NODE = 0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        desc_valid = 1'b0;
   logic [2:0]  desc_dest = '0;
   logic [0:0]  desc_vc = '0;
   logic [3:0]  desc_len = '0;
   logic        word_valid = 1'b0;
   logic [15:0] word_data = '0;
   logic [1:0]  vc_full = '0;
   logic        desc_ready;
   logic        word_ready;
   logic [17:0] flit_out;
   logic        flit_out_valid;
   logic        pkt_dropped;
   logic [15:0] pkt_sent_count;

   always #5 clk = ~clk;

   spidergon_ni_packetizer #(
      .NUM_OF_NODES            (8),
      .FLIT_DATA_WIDTH         (16),
      .NUM_OF_VIRTUAL_CHANNELS (2),
      .NODE_IDENTIFIER         (NODE),
      .FIFO_DEPTH              (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .desc_valid       (desc_valid),
      .desc_ready       (desc_ready),
      .desc_dest        (desc_dest),
      .desc_vc          (desc_vc),
      .desc_len         (desc_len),
      .word_valid       (word_valid),
      .word_ready       (word_ready),
      .word_data        (word_data),
      .flit_out         (flit_out),
      .flit_out_valid   (flit_out_valid),
      .flit_out_vc_full (vc_full),
      .pkt_dropped      (pkt_dropped),
      .pkt_sent_count   (pkt_sent_count)
   );

   typedef struct {
      int dest;
      int vc;
      int len;
   } pkt_t;

   pkt_t pkt_q[$];
   int   word_q[$];
   int   xfer_cyc[$];
   int   xfer_flit[$];
   int   idx = 0;
   int   exp_sent = 0;
   int   drops = 0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   pkt_t cp;
   int   cw;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   // Expected flit i of packet p (i=0 head, i=k carries k-th word w).
   function automatic int exp_flit(input pkt_t p, input int i,
                                   input int w);
      if (i == 0)
         return ((p.len == 0 ? 3 : 1) << 16) | (p.vc << 15) |
                (p.dest << 12) | (NODE << 9);
      return ((i == p.len ? 0 : 2) << 16) | (w & 16'hFFFF);
   endfunction

   function automatic int xc(input int k);
      if (xfer_cyc.size() > k)
         return xfer_cyc[xfer_cyc.size()-1-k];
      return -1000 * (k + 1);
   endfunction

   function automatic int xf(input int k);
      if (xfer_flit.size() > k)
         return xfer_flit[xfer_flit.size()-1-k];
      return -1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Packet-level model compare, once per cycle away from the edge.
   always @(negedge clk) begin
      if (reset) begin
         pkt_q.delete();
         word_q.delete();
         idx = 0;
         exp_sent = 0;
      end else begin
         chk("sent_count", {16'h0, pkt_sent_count}, exp_sent);
         if (pkt_dropped) begin
            if (pkt_q.size() > 0 && pkt_q[0].dest == NODE &&
                word_q.size() >= pkt_q[0].len) begin
               repeat (pkt_q[0].len) void'(word_q.pop_front());
               void'(pkt_q.pop_front());
               drops++;
            end else begin
               chk("unexpected_drop", 1, 0);
            end
         end
         if (flit_out_valid) begin
            if (pkt_q.size() == 0 || pkt_q[0].dest == NODE) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               cp = pkt_q[0];
               cw = 0;
               if (idx > 0) begin
                  if (word_q.size() >= idx)
                     cw = word_q[idx-1];
                  else
                     chk("word_available", 0, 1);
               end
               chk("flit", {14'h0, flit_out}, exp_flit(cp, idx, cw));
               if (!vc_full[cp.vc]) begin
                  xfer_cyc.push_back(cyc);
                  xfer_flit.push_back(int'(flit_out));
                  if (idx == cp.len) begin
                     repeat (cp.len) void'(word_q.pop_front());
                     void'(pkt_q.pop_front());
                     idx = 0;
                     exp_sent = (exp_sent + 1) & 16'hFFFF;
                  end else begin
                     idx++;
                  end
               end
            end
         end
      end
   end

   task automatic send_desc(input int dest, input int vc, input int len);
      int ok;
      ok = 0;
      desc_valid = 1'b1;
      desc_dest  = dest[2:0];
      desc_vc    = vc[0:0];
      desc_len   = len[3:0];
      for (int i = 0; i < 50 && ok == 0; i++) begin
         @(negedge clk);
         if (desc_ready) begin
            ok = 1;
            pkt_q.push_back('{dest, vc, len});
         end
         @(posedge clk);
         #1;
      end
      desc_valid = 1'b0;
      if (ok == 0) chk("desc_timeout", 0, 1);
   endtask

   task automatic push_word(input int d);
      int ok;
      ok = 0;
      word_valid = 1'b1;
      word_data  = d[15:0];
      for (int i = 0; i < 50 && ok == 0; i++) begin
         @(negedge clk);
         if (word_ready) begin
            ok = 1;
            word_q.push_back(d);
         end
         @(posedge clk);
         #1;
      end
      word_valid = 1'b0;
      if (ok == 0) chk("word_timeout", 0, 1);
   endtask

   task automatic drain();
      int ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pkt_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int d0;
      int c0;
      int hc;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", flit_out_valid, 0);
      chk("rst_flit", flit_out, 0);
      chk("rst_count", pkt_sent_count, 0);
      chk("rst_dropped", pkt_dropped, 0);
      chk("rst_desc_ready", desc_ready, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_desc_ready", desc_ready, 1);
      @(posedge clk);
      #1;

      // Header-only packet, latency 1
      send_desc(5, 1, 0);
      @(negedge clk);
      chk("hdr_only_valid", flit_out_valid, 1);
      chk("hdr_only_flit", flit_out, 18'h3D000);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("hdr_only_count", pkt_sent_count, 1);
      chk("hdr_only_valid_off", flit_out_valid, 0);
      @(posedge clk);
      #1;

      // Full-throughput 3-word packet
      push_word('hA1);
      push_word('hB2);
      push_word('hC3);
      send_desc(2, 0, 3);
      drain();
      chk("len3_consecutive", xc(0) - xc(3), 3);
      chk("len3_head", xf(3), 'h12000);
      chk("len3_body0", xf(2), 'h200A1);
      chk("len3_body1", xf(1), 'h200B2);
      chk("len3_tail", xf(0), 'h000C3);
      @(negedge clk);
      chk("len3_count", pkt_sent_count, 2);
      @(posedge clk);
      #1;

      // VC1 backpressure for 4 cycles mid-body; vc_full[0] ignored
      vc_full = 2'b01;
      push_word('h11);
      push_word('h22);
      push_word('h33);
      send_desc(3, 1, 3);
      @(posedge clk);
      #1 vc_full = 2'b11;
      repeat (4) begin
         @(negedge clk);
         chk("stall_hold_flit", flit_out, 'h20011);
         chk("stall_hold_valid", flit_out_valid, 1);
         @(posedge clk);
         #1;
      end
      vc_full = 2'b01;
      drain();
      vc_full = 2'b00;
      chk("stall_head", xf(3), 'h1B000);
      chk("stall_resume", xc(2) - xc(3), 5);
      chk("stall_tail_gap", xc(0) - xc(2), 2);

      // Packet addressed to self is dropped
      push_word('h55);
      push_word('h66);
      d0 = drops;
      c0 = int'(pkt_sent_count);
      send_desc(NODE, 0, 2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (drops > d0) break;
      end
      repeat (5) @(negedge clk);
      chk("drop_pulses", drops - d0, 1);
      chk("drop_count_same", pkt_sent_count, c0);
      @(posedge clk);
      #1;
      push_word('h77);
      send_desc(4, 0, 1);
      drain();
      chk("after_drop_tail", xf(0), 'h00077);

      // Zero-length drop
      d0 = drops;
      send_desc(NODE, 1, 0);
      repeat (4) @(negedge clk);
      chk("drop0_pulses", drops - d0, 1);
      @(posedge clk);
      #1;

      // Words withheld 3 cycles after head
      send_desc(6, 0, 2);
      repeat (2) @(posedge clk);
      #1;
      push_word('h1234);
      push_word('h5678);
      drain();
      hc = xc(2);
      chk("bubble_body_gap", xc(1) - hc, 4);
      chk("bubble_tail_gap", xc(0) - xc(1), 1);
      chk("bubble_tail", xf(0), 'h05678);

      // Reset mid-body
      push_word('hAA);
      push_word('hBB);
      push_word('hCC);
      send_desc(1, 0, 3);
      @(posedge clk);
      #1 vc_full = 2'b01;
      @(negedge clk);
      chk("midbody_valid", flit_out_valid, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_desc_ready", desc_ready, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      vc_full = 2'b00;
      @(negedge clk);
      chk("rst_mid_valid", flit_out_valid, 0);
      chk("rst_mid_desc_ready_after", desc_ready, 1);
      chk("rst_mid_count", pkt_sent_count, 0);
      @(posedge clk);
      #1;
      push_word('h99);
      send_desc(7, 1, 1);
      drain();
      chk("rst_fifo_empty_tail", xf(0), 'h00099);
      @(negedge clk);
      chk("rst_final_count", pkt_sent_count, 1);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spidergon_ni_packetizer.md
SPIDERGON_NI_PACKETIZER -- requirements
Module: spidergon_ni_packetizer

Interface
REQ-001 SHALL have parameter NUM_OF_NODES, default 8, ring size; DEST_W = $clog2(NUM_OF_NODES).
REQ-002 SHALL have parameter FLIT_DATA_WIDTH, default 16, payload bits per flit; flit width FLIT_W = FLIT_DATA_WIDTH+2.
REQ-003 SHALL have parameter NUM_OF_VIRTUAL_CHANNELS, default 2; VC_W = $clog2(NUM_OF_VIRTUAL_CHANNELS).
REQ-004 SHALL have parameter NODE_IDENTIFIER, default 0, index of the attached node.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, payload word buffer depth (power of two).
REQ-006 Ports: clk input 1, clock; reset input 1, reset, synchronous, active-high.
REQ-007 Ports: desc_valid input 1, descriptor offered; desc_ready output 1; desc_dest input DEST_W; desc_vc input VC_W; desc_len input 4, payload word count 0..15.
REQ-008 Ports: word_valid input 1; word_ready output 1; word_data input FLIT_DATA_WIDTH, payload word stream.
REQ-009 Ports: flit_out output FLIT_W; flit_out_valid output 1; flit_out_vc_full input NUM_OF_VIRTUAL_CHANNELS, per-VC on/off backpressure from the node.
REQ-010 Ports: pkt_dropped output 1, one-cycle pulse; pkt_sent_count output 16, completed packets.

Function
REQ-011 Flit type field [FLIT_W-1:FLIT_W-2] SHALL be 01 head, 10 body, 00 tail, 11 header-only.
REQ-012 Head/header-only flit SHALL carry vc at [FLIT_W-3 -: VC_W], dest at the next DEST_W bits below, NODE_IDENTIFIER as source at the next DEST_W bits, remaining bits zero.
REQ-013 Body/tail flits SHALL carry the payload word in [FLIT_DATA_WIDTH-1:0].
REQ-014 desc_len=0 SHALL emit one header-only flit; len=n>=1 SHALL emit head, n-1 body, then tail (tail carries last word).
REQ-015 FSM states SHALL be IDLE, HEAD, BODY, DROP; desc_ready=1 only in IDLE; descriptor captured on desc_valid&&desc_ready.
REQ-016 IDLE->HEAD on accept with dest!=NODE_IDENTIFIER; IDLE->DROP on accept with dest==NODE_IDENTIFIER.
REQ-017 Flit transfer SHALL occur in a cycle where flit_out_valid && !flit_out_vc_full[captured vc].
REQ-018 flit_out SHALL be registered; head valid the cycle after descriptor accept (latency 1).
REQ-019 While flit_out_valid && not transferred, flit_out and flit_out_valid SHALL hold stable.
REQ-020 Next flit SHALL load the same cycle the current one transfers (full throughput, one flit/cycle) when a payload word is available.
REQ-021 FIFO empty when a body/tail flit is due SHALL deassert flit_out_valid (bubble); no premature tail.
REQ-022 HEAD->BODY on head transfer (len>=1); HEAD->IDLE on header-only transfer; BODY->IDLE on tail transfer.
REQ-023 word_ready SHALL equal FIFO not full in every state; words for a following packet MAY be prefetched.
REQ-024 DROP SHALL pop exactly desc_len words (waiting on empty FIFO), emit no flits, pulse pkt_dropped in the cycle returning to IDLE (len 0: next cycle).
REQ-025 pkt_sent_count SHALL increment on each tail or header-only transfer, wrapping 0xFFFF->0.

Reset
REQ-026 On reset: state IDLE, flit_out=0, flit_out_valid=0, pkt_dropped=0, pkt_sent_count=0, FIFO empty, desc_ready=0 during reset cycle.
REQ-027 Reset mid-packet SHALL abandon the packet; no tail emitted; buffered words discarded.

Structure
REQ-028 Flit type codes, field offsets, and FSM state encoding SHALL live in shared package spidergon_pkg.
REQ-029 Payload buffer SHALL be sub-module spidergon_sync_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-030 len=0, dest=5, vc=1, vc_full=00 -> next cycle single flit type 11, vc 1, dest 5, source 0; count=1.
REQ-031 len=3, words 0xA1,0xB2,0xC3, dest=2 -> head, body 0xA1, body 0xB2, tail 0xC3 on 4 consecutive cycles.
REQ-032 vc_full[1]=1 for 4 cycles during body of vc1 packet -> flit held unchanged, resumes next cycle after release; vc_full[0] ignored.
REQ-033 dest=NODE_IDENTIFIER, len=2 -> two words consumed, no flit_out_valid, one pkt_dropped pulse, count unchanged.
REQ-034 word_valid withheld 3 cycles after head of len=2 -> valid low 3 cycles, then body, tail in order.
REQ-035 reset asserted mid-body -> next cycle flit_out_valid=0, FIFO empty, desc_ready=1 the cycle after reset release.
